// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gcd_pkg
//  Description : Shared types and default parameters for the GCD requester
//                slice (requester FSM states, operand width, watchdog limit).
//  Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

  // Default operand/result width; must match the attached core.
  localparam int NBITS_DEFAULT   = 2;
  // Default maximum number of RUN cycles before the watchdog aborts.
  localparam int TIMEOUT_DEFAULT = 64;

  // Requester FSM states. The encoding is fixed so the top-level
  // localparam aliases stay legacy-compatible.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_RESP  = 3'd3,
    ST_ABORT = 3'd4,
    ST_DRAIN = 3'd5
  } req_state_e;

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_watchdog
//  Description : Saturating cycle counter that flags when a computation has
//                been running for TIMEOUT cycles.
//  Ports       : clk     - clock, rising edge
//                rst_n   - asynchronous active-low reset
//                clear   - synchronous clear of the count
//                enable  - count this cycle (one count per RUN cycle)
//                expired - high during the TIMEOUT-th enabled cycle onwards
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_watchdog
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT   // must be >= 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Saturates at TIMEOUT so the count never wraps back to a "fresh" value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds the number of completed enabled cycles, so the current
  // cycle is the TIMEOUT-th one when r_count has reached TIMEOUT-1. Flagging
  // it combinationally lets the FSM leave RUN after exactly TIMEOUT cycles.
  assign expired = enable && (r_count >= CW'(TIMEOUT - 1));

endmodule : gcd_watchdog
`default_nettype wire

// File: rtl/gcd_requester.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_requester
//  Description : Initiator for a start/rdy GCD core. Accepts operand pairs on
//                a valid/ready stream, sequences the core through
//                load -> compute -> result, and returns the result on a
//                valid/ready stream. A watchdog aborts a hung computation.
//  Ports       : clk, rst_n                 - clock / async active-low reset
//                in_valid, in_ready         - operand stream handshake
//                in_a, in_b                 - operands (MSB must be 0)
//                gcd_xi, gcd_yi             - operands to core
//                gcd_start                  - 0 = core loads, 1 = core computes
//                gcd_rst                    - active-high core reset
//                gcd_rdy, gcd_xo            - core result valid / value
//                out_valid, out_ready       - result stream handshake
//                out_gcd, out_err           - result / invalid-result flag
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int NBits   = NBITS_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBits-1:0] in_a,
  input  logic [NBits-1:0] in_b,
  output logic [NBits-1:0] gcd_xi,
  output logic [NBits-1:0] gcd_yi,
  output logic             gcd_start,
  output logic             gcd_rst,
  input  logic             gcd_rdy,
  input  logic [NBits-1:0] gcd_xo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBits-1:0] out_gcd,
  output logic             out_err
);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_LOAD  = 3'(ST_LOAD);
  localparam logic [2:0] S_RUN   = 3'(ST_RUN);
  localparam logic [2:0] S_RESP  = 3'(ST_RESP);
  localparam logic [2:0] S_ABORT = 3'(ST_ABORT);
  localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);

  logic [2:0]       r_state;
  logic [NBits-1:0] r_a;
  logic [NBits-1:0] r_b;
  logic [NBits-1:0] r_gcd;
  logic             r_err;
  logic             r_used_core;   // current request went through the core

  logic w_bad_op;
  logic w_zero_op;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_bad_op  = in_a[NBits-1] | in_b[NBits-1];
  assign w_zero_op = (in_a == '0) | (in_b == '0);

  // Every entry to RUN comes from LOAD, so clearing during LOAD gives a
  // fresh count on the first RUN cycle.
  assign w_wd_clear  = (r_state == S_LOAD);
  assign w_wd_enable = (r_state == S_RUN);

  gcd_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_gcd       <= '0;
      r_err       <= 1'b0;
      r_used_core <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
            if (w_bad_op) begin
              r_gcd       <= '0;
              r_err       <= 1'b1;
              r_used_core <= 1'b0;
              r_state     <= S_RESP;
            end else if (w_zero_op) begin
              r_gcd       <= '0;
              r_err       <= 1'b0;
              r_used_core <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              r_used_core <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          // A result arriving on the timeout edge is kept.
          if (gcd_rdy) begin
            r_gcd   <= gcd_xo;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_wd_expired) begin
            r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          r_gcd   <= '0;
          r_err   <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_state <= r_used_core ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // rst_n is folded in so in_ready is low and the core is held in reset
  // for the whole reset interval, not just from the first clock edge.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign gcd_rst   = !rst_n || (r_state == S_ABORT);
  assign gcd_start = (r_state == S_RUN);
  assign gcd_xi    = ((r_state == S_LOAD) || (r_state == S_RUN)) ? r_a : '0;
  assign gcd_yi    = ((r_state == S_LOAD) || (r_state == S_RUN)) ? r_b : '0;
  assign out_valid = (r_state == S_RESP);
  assign out_gcd   = r_gcd;
  assign out_err   = r_err;

endmodule : gcd_requester
`default_nettype wire

// File: tb/tb_gcd_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_requester
//  Description : Directed self-checking bench for gcd_requester with a
//                behavioural subtractive GCD core (optionally stubbed to
//                never assert rdy).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_requester;

  localparam int NB = 8;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic [NB-1:0] gcd_xi;
  logic [NB-1:0] gcd_yi;
  logic          gcd_start;
  logic          gcd_rst;
  logic          gcd_rdy;
  logic [NB-1:0] gcd_xo;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_gcd;
  logic          out_err;

  int n_cmp = 0;
  int n_err = 0;

  gcd_requester #(
    .NBits   (NB),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .gcd_xi    (gcd_xi),
    .gcd_yi    (gcd_yi),
    .gcd_start (gcd_start),
    .gcd_rst   (gcd_rst),
    .gcd_rdy   (gcd_rdy),
    .gcd_xo    (gcd_xo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: loads while start=0, subtracts while start=1, and
  // raises rdy once both registers agree. stub_hold masks rdy entirely.
  logic [NB-1:0] c_x;
  logic [NB-1:0] c_y;
  logic          c_rdy;
  logic [NB-1:0] c_xo;
  logic          stub_hold;

  always @(posedge clk) begin
    if (gcd_rst) begin
      c_x   <= '0;
      c_y   <= '0;
      c_rdy <= 1'b0;
      c_xo  <= '0;
    end else if (!gcd_start) begin
      c_x   <= gcd_xi;
      c_y   <= gcd_yi;
      c_rdy <= 1'b0;
    end else if (c_x == c_y) begin
      c_rdy <= 1'b1;
      c_xo  <= c_x;
    end else if (c_x > c_y) begin
      c_x <= c_x - c_y;
    end else begin
      c_y <= c_y - c_x;
    end
  end

  assign gcd_rdy = stub_hold ? 1'b0 : c_rdy;
  assign gcd_xo  = c_xo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one pair and wait (bounded) for out_valid. Reports cycles from the
  // accept edge to RESP, start-high cycles, gcd_rst-high cycles, and whether
  // rdy was high in the cycle just before RESP.
  task automatic run_req(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         output int waits, output int runs, output int rsts,
                         output logic pre_rdy);
    chk("in_ready_before_req", in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    waits    = 0;
    runs     = 0;
    rsts     = 0;
    pre_rdy  = 1'b0;
    while (!out_valid && waits < 100) begin
      runs   += int'(gcd_start);
      rsts   += int'(gcd_rst);
      pre_rdy = gcd_rdy;
      tick();
      waits++;
    end
    chk("resp_within_budget", out_valid, 1);
  endtask

  // Complete the output handshake; a core request is followed by DRAIN.
  task automatic take_out(input bit used_core);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk(used_core ? "in_ready_drain" : "in_ready_bypass", in_ready, used_core ? 0 : 1);
    if (used_core) tick();
  endtask

  int   w, r, g;
  logic pr;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    stub_hold = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_gcd_rst", gcd_rst, 1);
    chk("rst_gcd_xi", gcd_xi, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_gcd_rst", gcd_rst, 0);
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // 1. Nominal 12,18 -> 6: one LOAD cycle then start high until rdy.
    in_a = 8'd12; in_b = 8'd18; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_load_start", gcd_start, 0);
    chk("t1_load_xi", gcd_xi, 12);
    chk("t1_load_yi", gcd_yi, 18);
    chk("t1_load_in_ready", in_ready, 0);
    tick();
    chk("t1_run_start", gcd_start, 1);
    w = 0;
    while (!out_valid && w < 100) begin
      tick();
      w++;
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_run_cycles_after_first", w, 4);
    chk("t1_gcd", out_gcd, 6);
    chk("t1_err", out_err, 0);
    take_out(1);

    // 2. Equal operands and back-to-back follow-up.
    run_req(8'd7, 8'd7, w, r, g, pr);
    chk("t2_gcd", out_gcd, 7);
    chk("t2_err", out_err, 0);
    chk("t2_rdy_then_valid", pr, 1);
    chk("t2_waits", w, 3);
    take_out(1);
    run_req(8'd9, 8'd6, w, r, g, pr);
    chk("t2b_gcd", out_gcd, 3);
    chk("t2b_runs", r, 4);
    chk("t2b_waits", w, 5);
    take_out(1);

    // 3. Zero bypass and bad operand: core never started.
    run_req(8'd0, 8'd5, w, r, g, pr);
    chk("t3_zero_gcd", out_gcd, 0);
    chk("t3_zero_err", out_err, 0);
    chk("t3_zero_latency", w, 0);
    chk("t3_zero_no_start", r, 0);
    take_out(0);
    run_req(8'h80, 8'd3, w, r, g, pr);
    chk("t3_bad_gcd", out_gcd, 0);
    chk("t3_bad_err", out_err, 1);
    chk("t3_bad_no_start", r, 0);
    chk("t3_bad_no_rst", g, 0);
    take_out(0);

    // 4. Timeout with rdy held low: 8 RUN cycles, one ABORT cycle.
    stub_hold = 1'b1;
    run_req(8'd10, 8'd4, w, r, g, pr);
    chk("t4_run_cycles", r, TO);
    chk("t4_rst_pulses", g, 1);
    chk("t4_waits", w, TO + 2);
    chk("t4_gcd", out_gcd, 0);
    chk("t4_err", out_err, 1);
    chk("t4_rst_released", gcd_rst, 0);
    take_out(1);
    stub_hold = 1'b0;

    // 5. Backpressure: result stays stable, no new input accepted.
    run_req(8'd15, 8'd25, w, r, g, pr);
    chk("t5_waits", w, 6);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_gcd", out_gcd, 5);
      chk("t5_hold_in_ready", in_ready, 0);
      tick();
    end
    chk("t5_final_gcd", out_gcd, 5);
    take_out(1);

    // 6. Reset during RUN, then a clean retry.
    in_a = 8'd100; in_b = 8'd75; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_in_run", gcd_start, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", gcd_start, 0);
    chk("t6_rst_gcd_rst", gcd_rst, 1);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_xi", gcd_xi, 0);
    chk("t6_rst_out_gcd", out_gcd, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_post_out_valid", out_valid, 0);
    tick();
    run_req(8'd100, 8'd75, w, r, g, pr);
    chk("t6_gcd", out_gcd, 25);
    chk("t6_err", out_err, 0);
    take_out(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_gcd_requester
`default_nettype wire
